// File: rtl/mpsoc_noc_pkg.sv
// Shared definitions for the NoC virtual-channel link arbiter: default sizes,
// link ownership states and a small wrap-around index helper.
package mpsoc_noc_pkg;

   localparam int unsigned NOC_FLIT_WIDTH = 34;
   localparam int unsigned NOC_CHANNELS   = 9;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } link_state_e;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr_i,
// wrapping from CHANNELS-1 back to 0, wins.
module noc_rr_arbiter #(
   parameter int unsigned  CHANNELS = mpsoc_noc_pkg::NOC_CHANNELS,
   localparam int unsigned IDX_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [IDX_W-1:0]    ptr_i,
   output logic [CHANNELS-1:0] gnt_o,
   output logic [IDX_W-1:0]    idx_o,
   output logic                valid_o
);

   logic [IDX_W-1:0] cand;

   // NOTE: blocking assignments with every output defaulted first, so no latch is inferred.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int unsigned off = 0; off < CHANNELS; off++) begin
         cand = IDX_W'((32'(ptr_i) + off) % CHANNELS);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_vc_arbiter.sv
// Multiplexes CHANNELS virtual channels onto one registered link; a packet
// keeps the link from its first flit until its last flit is accepted.
module noc_vc_arbiter
   import mpsoc_noc_pkg::*;
#(
   parameter int unsigned  FLIT_WIDTH = NOC_FLIT_WIDTH,
   parameter int unsigned  CHANNELS   = NOC_CHANNELS,
   localparam int unsigned IDX_W      = $clog2(CHANNELS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
   input  logic [CHANNELS-1:0]                 in_last,
   input  logic [CHANNELS-1:0]                 in_valid,
   output logic [CHANNELS-1:0]                 in_ready,
   input  logic [CHANNELS-1:0]                 cfg_enable,
   output logic [FLIT_WIDTH-1:0]               out_flit,
   output logic                                out_last,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [IDX_W-1:0]                    out_channel
);

   link_state_e           state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [FLIT_WIDTH-1:0] flit_q, flit_d;
   logic                  last_q, last_d;
   logic                  valid_q, valid_d;
   logic [IDX_W-1:0]      chan_q, chan_d;

   logic                  load_en;
   logic                  accept;
   logic [IDX_W-1:0]      sel_idx;
   logic [CHANNELS-1:0]   arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;

   assign load_en = !valid_q || out_ready;

   noc_rr_arbiter #(
      .CHANNELS(CHANNELS)
   ) u_rr (
      .req_i  (in_valid & cfg_enable),
      .ptr_i  (ptr_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx),
      .valid_o(arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      in_ready = '0;
      accept   = 1'b0;
      sel_idx  = grant_q;

      // The enable mask only matters for new arbitration; a locked packet ignores it.
      if (rst && load_en) begin
         unique case (state_q)
            IDLE: begin
               in_ready = arb_gnt;
               accept   = arb_valid;
               sel_idx  = arb_idx;
            end
            LOCKED: begin
               in_ready[grant_q] = 1'b1;
               accept            = in_valid[grant_q];
            end
         endcase
      end

      if (accept) begin
         grant_d = sel_idx;
         if (in_last[sel_idx]) begin
            state_d = IDLE;
            ptr_d   = IDX_W'(wrap_inc(32'(sel_idx), CHANNELS));
         end else begin
            state_d = LOCKED;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      flit_d  = flit_q;
      last_d  = last_q;
      chan_d  = chan_q;
      if (load_en) begin
         valid_d = accept;
      end
      if (accept) begin
         flit_d = in_flit[sel_idx];
         last_d = in_last[sel_idx];
         chan_d = sel_idx;
      end
   end

   // NOTE: the link data register is reset with the control state so a reset never leaves a stale flit visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         flit_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         chan_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         flit_q  <= flit_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         chan_q  <= chan_d;
      end
   end

   assign out_flit    = flit_q;
   assign out_last    = last_q;
   assign out_valid   = valid_q;
   assign out_channel = chan_q;

endmodule

// File: tb/tb_noc_vc_arbiter.sv
// Self-checking bench for noc_vc_arbiter: per-VC packet queues feed the DUT and
// a queue-based link model predicts every acceptance and every output cycle.
module tb_noc_vc_arbiter;

   localparam int CH = 9;
   localparam int FW = 34;
   localparam int IW = $clog2(CH);

   typedef struct packed {
      logic [FW-1:0] data;
      logic          last;
   } flit_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [CH-1:0][FW-1:0] in_flit;
   logic [CH-1:0]         in_last;
   logic [CH-1:0]         in_valid;
   logic [CH-1:0]         in_ready;
   logic [CH-1:0]         cfg_enable;
   logic [FW-1:0]         out_flit;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [IW-1:0]         out_channel;

   always #5 clk = ~clk;

   noc_vc_arbiter #(
      .FLIT_WIDTH(FW),
      .CHANNELS  (CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_flit    (in_flit),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cfg_enable (cfg_enable),
      .out_flit   (out_flit),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_channel(out_channel)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   flit_t         srcq[CH][$];
   logic [CH-1:0] gate;
   logic [CH-1:0] cfg;
   int            seen[$];

   // Link model: who owns the link, where round-robin resumes, what the register holds.
   bit    m_locked;
   int    m_owner;
   int    m_ptr;
   bit    m_ov;
   flit_t m_out;
   int    m_oc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic check_seq(input string tag, input int expq[$]);
      check({tag, "_len"}, 64'(seen.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < seen.size(); i++)
         check(tag, 64'(seen[i]), 64'(expq[i]));
   endtask

   task automatic add_packet(input int vc, input int len);
      flit_t f;
      for (int i = 0; i < len; i++) begin
         f.data = {2'($urandom_range(3, 0)), 32'($urandom)};
         f.last = (i == len - 1);
         srcq[vc].push_back(f);
      end
   endtask

   task automatic drive();
      for (int v = 0; v < CH; v++) begin
         if (srcq[v].size() > 0) begin
            in_valid[v] = gate[v];
            in_flit[v]  = srcq[v][0].data;
            in_last[v]  = srcq[v][0].last;
         end else begin
            in_valid[v] = 1'b0;
            in_flit[v]  = '0;
            in_last[v]  = 1'b0;
         end
      end
      cfg_enable = cfg;
   endtask

   // One link cycle: drive, predict, compare, clock, advance the model.
   task automatic step();
      int            win;
      int            v;
      bit            load;
      logic [CH-1:0] exp_vec;
      flit_t         f;
      drive();
      #2;
      load = !m_ov || out_ready;
      win  = -1;
      if (load) begin
         if (m_locked) begin
            if (in_valid[m_owner]) win = m_owner;
         end else begin
            for (int k = 0; k < CH; k++) begin
               v = (m_ptr + k) % CH;
               if (win < 0 && in_valid[v] && cfg[v]) win = v;
            end
         end
      end
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
         check("out_flit", 64'(out_flit), 64'(m_out.data));
         check("out_last", 64'(out_last), 64'(m_out.last));
         check("out_channel", 64'(out_channel), 64'(m_oc));
      end
      exp_vec = '0;
      if (win >= 0) exp_vec[win] = 1'b1;
      check("accept", 64'(in_ready & in_valid), 64'(exp_vec));
      if (!load) check("stall_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) seen.push_back(int'(out_channel));
      @(posedge clk);
      #1;
      if (load) begin
         m_ov = (win >= 0);
         if (win >= 0) begin
            m_out = srcq[win][0];
            m_oc  = win;
         end
      end
      if (win >= 0) begin
         f = srcq[win].pop_front();
         if (f.last) begin
            m_locked = 1'b0;
            m_ptr    = (win + 1) % CH;
         end else begin
            m_locked = 1'b1;
            m_owner  = win;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int v = 0; v < CH; v++) srcq[v].delete();
      gate      = '1;
      cfg       = '1;
      out_ready = 1'b1;
      add_packet(3, 1);
      drive();
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_flit", 64'(out_flit), 64'd0);
      check("rst_out_channel", 64'(out_channel), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      srcq[3].delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b1;
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_ov     = 1'b0;
      m_out    = '0;
      m_oc     = 0;
      seen.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      in_flit    = '0;
      in_last    = '0;
      in_valid   = '0;
      cfg_enable = '1;
      out_ready  = 1'b1;
      gate       = '1;
      cfg        = '1;
      #1;

      // Two simultaneous 3-flit packets: VC2 wins from ptr 0, VC5 follows.
      do_reset();
      add_packet(2, 3);
      add_packet(5, 3);
      repeat (7) step();
      q = {2, 2, 2, 5, 5, 5};
      check_seq("two_vc", q);
      repeat (3) step();

      // Every VC streams single-flit packets: full rotation with no bubble.
      do_reset();
      q.delete();
      for (int r = 0; r < 2; r++)
         for (int v = 0; v < CH; v++) begin
            add_packet(v, 1);
            q.push_back(v);
         end
      repeat (19) step();
      check_seq("rotate", q);

      // Downstream stall mid-packet on VC4 with VC0 waiting.
      do_reset();
      add_packet(4, 4);
      repeat (2) step();
      add_packet(0, 1);
      out_ready = 1'b0;
      repeat (5) step();
      out_ready = 1'b1;
      repeat (6) step();
      q = {4, 4, 4, 4, 0};
      check_seq("stall", q);

      // Disabling VC3 mid-packet does not cut it; it is not regranted while disabled.
      do_reset();
      add_packet(3, 4);
      add_packet(6, 1);
      step();
      cfg[3] = 1'b0;
      add_packet(3, 2);
      repeat (10) step();
      q = {3, 3, 3, 3, 6};
      check_seq("mask", q);

      // Asynchronous reset while flit 2 of VC1 sits in the output register.
      do_reset();
      add_packet(1, 4);
      repeat (2) step();
      #2;
      rst = 1'b0;
      #1;
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_in_ready", 64'(in_ready), 64'd0);
      do_reset();
      add_packet(1, 4);
      add_packet(0, 1);
      repeat (7) step();
      q = {0, 1, 1, 1, 1};
      check_seq("post_reset", q);

      // VC7 pauses mid-packet; VC0 must wait for its last flit.
      do_reset();
      add_packet(7, 4);
      step();
      add_packet(0, 1);
      gate[7] = 1'b0;
      repeat (3) step();
      gate[7] = 1'b1;
      repeat (6) step();
      q = {7, 7, 7, 7, 0};
      check_seq("gap", q);

      // Random traffic, valid gaps, mask changes and backpressure.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         int v;
         if ($urandom_range(3, 0) == 0) begin
            v = $urandom_range(CH - 1, 0);
            if (srcq[v].size() < 8) add_packet(v, $urandom_range(4, 1));
         end
         gate = CH'($urandom | $urandom);
         if (c % 50 == 0) cfg = CH'($urandom | $urandom);
         out_ready = ($urandom_range(9, 0) < 7);
         step();
      end
      gate      = '1;
      cfg       = '1;
      out_ready = 1'b1;
      repeat (120) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
